// File: rtl/r_type_issue_ctrl.sv
// Multi-cycle R-type issue controller: IDLE/DECODE/EXEC/WB around an external combinational ALU.
// Optional OVF_TRAP_EN: signed add/sub overflow is detected locally and traps (no writeback, err set).
module r_type_issue_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   input  logic        load_en,
   input  logic [4:0]  load_addr,
   input  logic [31:0] load_data,
   output logic [2:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   input  logic        alu_zf,
   input  logic        alu_of,
   output logic        done,
   output logic        err,
   output logic        zf_q,
   output logic        of_q,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);
   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
   state_t state_q, state_d;

   logic [31:0] rf_q [32];
   logic [5:0]  opc_q, funct_q;
   logic [4:0]  rs_q, rt_q, rd_q;
   logic [2:0]  alu_op_q, op_d;
   logic [31:0] alu_a_q, alu_b_q, res_q;
   logic        illegal_q, illegal_d, zf_c_q, of_c_q, trap_q, of_c_d, trap_d;
   logic        err_q, zf_out_q, of_out_q;
   logic        accept, wb_we;
   logic        unused_bits;

   assign accept = instr_valid && instr_ready;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next state: fixed latency, illegal instructions walk the same path
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = DECODE;
         DECODE:  state_d = EXEC;
         EXEC:    state_d = WB;
         default: state_d = IDLE;
      endcase
   end

   // outputs
   always_comb begin
      instr_ready = (state_q == IDLE) && !load_en;
      done        = (state_q == WB);
   end

   always_comb begin
      illegal_d = 1'b0;
      op_d      = 3'b000;
      if (opc_q != 6'b000000) illegal_d = 1'b1;
      else begin
         case (funct_q)
            6'b100100: op_d = 3'b000;
            6'b100101: op_d = 3'b001;
            6'b100110: op_d = 3'b010;
            6'b100111: op_d = 3'b011;
            6'b100000: op_d = 3'b100;
            6'b100010: op_d = 3'b101;
            6'b101010: op_d = 3'b110;
            6'b000100: op_d = 3'b111;
            default:   illegal_d = 1'b1;
         endcase
      end
   end

`ifdef OVF_TRAP_EN
   logic unused_of;
   assign unused_of = alu_of;
   always_comb begin
      of_c_d = 1'b0;
      if (alu_op_q == 3'b100)
         of_c_d = (alu_a_q[31] == alu_b_q[31]) && (alu_result[31] != alu_a_q[31]);
      else if (alu_op_q == 3'b101)
         of_c_d = (alu_a_q[31] != alu_b_q[31]) && (alu_result[31] != alu_a_q[31]);
      trap_d = of_c_d;
   end
`else
   always_comb begin
      of_c_d = alu_of;
      trap_d = 1'b0;
   end
`endif

   assign wb_we = (state_q == WB) && !illegal_q && !trap_q && (rd_q != 5'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         {opc_q, funct_q, rs_q, rt_q, rd_q} <= '0;
         alu_op_q  <= 3'b000;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         res_q     <= '0;
         illegal_q <= 1'b0;
         zf_c_q    <= 1'b0;
         of_c_q    <= 1'b0;
         trap_q    <= 1'b0;
         err_q     <= 1'b0;
         zf_out_q  <= 1'b0;
         of_out_q  <= 1'b0;
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load_en && load_addr != 5'd0) rf_q[load_addr] <= load_data;
               if (accept) begin
                  opc_q   <= instr[31:26];
                  rs_q    <= instr[25:21];
                  rt_q    <= instr[20:16];
                  rd_q    <= instr[15:11];
                  funct_q <= instr[5:0];
               end
            end
            DECODE: begin
               alu_a_q   <= rf_q[rs_q];
               alu_b_q   <= rf_q[rt_q];
               alu_op_q  <= op_d;
               illegal_q <= illegal_d;
            end
            EXEC: begin
               res_q  <= alu_result;
               zf_c_q <= alu_zf;
               of_c_q <= of_c_d;
               trap_q <= trap_d;
            end
            default: begin
               if (wb_we) rf_q[rd_q] <= res_q;
               if (!illegal_q) begin
                  zf_out_q <= zf_c_q;
                  of_out_q <= of_c_q;
               end
               err_q <= err_q | illegal_q | trap_q;
            end
         endcase
      end
   end

   assign alu_op      = alu_op_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign err         = err_q;
   assign zf_q        = zf_out_q;
   assign of_q        = of_out_q;
   assign dbg_data    = (dbg_addr == 5'd0) ? 32'd0 : rf_q[dbg_addr];
   assign unused_bits = ^instr[10:6];
endmodule
